// File: rtl/fb_write_scheduler.sv
// fb_write_scheduler: owns the LED panel framebuffer write port, streaming
// validated UDP pixel packets into one panel or an idle-time fill pattern into all.
module fb_write_scheduler #(
  parameter int          PANELS      = 6,
  parameter logic [15:0] UDP_PORT    = 16'h6661,
  parameter logic [7:0]  MAGIC       = 8'hC5,
  parameter int          IDLE_CYCLES = 25_000_000,
  parameter int          FILL_WORDS  = 4096
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              udp_source_valid,
  input  logic              udp_source_last,
  output logic              udp_source_ready,
  input  logic [15:0]       udp_source_dst_port,
  input  logic [3:0]        udp_source_error,
  input  logic [31:0]       udp_source_data,
  output logic [PANELS-1:0] ctrl_en,
  output logic [3:0]        ctrl_wr,
  output logic [15:0]       ctrl_addr,
  output logic [23:0]       ctrl_wdat,
  output logic              pattern_active,
  output logic [15:0]       drop_count
);

  localparam int IDLE_W = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES) : 1;
  localparam int FILL_W = (FILL_WORDS > 1) ? $clog2(FILL_WORDS) : 1;
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_CYCLES - 1);
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(FILL_WORDS - 1);
  localparam logic [23:0] GREEN = 24'h00FF00;
  localparam logic [23:0] BLUE  = 24'h0000FF;

  typedef enum logic [1:0] {S_IDLE, S_PIX, S_DROP, S_PATTERN} state_t;

  state_t            state, state_n;
  logic [7:0]        panel, panel_n;
  logic [15:0]       pix_addr, pix_addr_n;
  logic [IDLE_W-1:0] idle_cnt, idle_cnt_n;
  logic [FILL_W-1:0] pat_addr, pat_addr_n;
  logic              pat_blue, pat_blue_n;

  logic              wr_en;
  logic [PANELS-1:0] wr_mask;
  logic [15:0]       wr_addr;
  logic [23:0]       wr_data;
  logic              drop_hit;
  logic              beat;
  logic              header_ok;

  // Ready never looks at valid, so the source can never see a combinational loop.
  assign udp_source_ready = ~reset & (state != S_PATTERN);
  assign beat             = udp_source_valid & udp_source_ready;

  assign header_ok = (udp_source_dst_port == UDP_PORT)
                   && (udp_source_error == 4'd0)
                   && (udp_source_data[23:16] == MAGIC)
                   && ({24'd0, udp_source_data[31:24]} < PANELS);

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    state_n    = state;
    panel_n    = panel;
    pix_addr_n = pix_addr;
    idle_cnt_n = '0;
    pat_addr_n = '0;
    pat_blue_n = 1'b0;
    wr_en      = 1'b0;
    wr_mask    = '0;
    wr_addr    = pix_addr;
    wr_data    = udp_source_data[23:0];
    drop_hit   = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (beat) begin
          if (header_ok) begin
            panel_n    = udp_source_data[31:24];
            pix_addr_n = udp_source_data[15:0];
            if (!udp_source_last) state_n = S_PIX;
          end else begin
            drop_hit = 1'b1;
            if (!udp_source_last) state_n = S_DROP;
          end
        end else if (!udp_source_valid) begin
          if (idle_cnt == IDLE_LAST) state_n = S_PATTERN;
          else                       idle_cnt_n = idle_cnt + 1'b1;
        end
      end

      S_PIX: begin
        if (beat) begin
          wr_en      = 1'b1;
          wr_mask    = PANELS'(1) << panel;
          pix_addr_n = pix_addr + 16'd1;
          if (udp_source_last) state_n = S_IDLE;
        end
      end

      S_DROP: begin
        if (beat && udp_source_last) state_n = S_IDLE;
      end

      S_PATTERN: begin
        wr_en      = 1'b1;
        wr_mask    = '1;
        wr_addr    = 16'(pat_addr);
        wr_data    = pat_blue ? BLUE : GREEN;
        pat_addr_n = (pat_addr == FILL_LAST) ? '0 : pat_addr + 1'b1;
        pat_blue_n = (pat_addr == FILL_LAST) ? ~pat_blue : pat_blue;
        // The waiting beat stays on the bus; it is taken once back in IDLE.
        if (udp_source_valid) state_n = S_IDLE;
      end
    endcase
  end

  // NOTE: registers use non-blocking assignments so each one samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      panel          <= '0;
      pix_addr       <= '0;
      idle_cnt       <= '0;
      pat_addr       <= '0;
      pat_blue       <= 1'b0;
      ctrl_en        <= '0;
      ctrl_wr        <= '0;
      ctrl_addr      <= '0;
      ctrl_wdat      <= '0;
      pattern_active <= 1'b0;
      drop_count     <= '0;
    end else begin
      panel          <= panel_n;
      pix_addr       <= pix_addr_n;
      idle_cnt       <= idle_cnt_n;
      pat_addr       <= pat_addr_n;
      pat_blue       <= pat_blue_n;
      ctrl_en        <= wr_mask;
      ctrl_wr        <= wr_en ? 4'b0111 : 4'b0000;
      pattern_active <= (state == S_PATTERN);
      if (wr_en) begin
        ctrl_addr <= wr_addr;
        ctrl_wdat <= wr_data;
      end
      if (drop_hit && (drop_count != 16'hFFFF)) drop_count <= drop_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_fb_write_scheduler.sv
// Self-checking bench for fb_write_scheduler: a packet-level model checked every
// cycle, plus directed scenarios with hand-computed write sequences.
module tb_fb_write_scheduler;

  localparam int          PANELS      = 6;
  localparam int          IDLE_CYCLES = 16;
  localparam int          FILL_WORDS  = 8;
  localparam logic [15:0] PORT        = 16'h6661;
  localparam logic [23:0] GREEN       = 24'h00FF00;
  localparam logic [23:0] BLUE        = 24'h0000FF;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              udp_source_valid = 1'b0;
  logic              udp_source_last = 1'b0;
  logic              udp_source_ready;
  logic [15:0]       udp_source_dst_port = 16'd0;
  logic [3:0]        udp_source_error = 4'd0;
  logic [31:0]       udp_source_data = 32'd0;
  logic [PANELS-1:0] ctrl_en;
  logic [3:0]        ctrl_wr;
  logic [15:0]       ctrl_addr;
  logic [23:0]       ctrl_wdat;
  logic              pattern_active;
  logic [15:0]       drop_count;

  fb_write_scheduler #(
    .PANELS(PANELS), .UDP_PORT(PORT), .MAGIC(8'hC5),
    .IDLE_CYCLES(IDLE_CYCLES), .FILL_WORDS(FILL_WORDS)
  ) dut (
    .clock(clock), .reset(reset),
    .udp_source_valid(udp_source_valid), .udp_source_last(udp_source_last),
    .udp_source_ready(udp_source_ready), .udp_source_dst_port(udp_source_dst_port),
    .udp_source_error(udp_source_error), .udp_source_data(udp_source_data),
    .ctrl_en(ctrl_en), .ctrl_wr(ctrl_wr), .ctrl_addr(ctrl_addr), .ctrl_wdat(ctrl_wdat),
    .pattern_active(pattern_active), .drop_count(drop_count)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;
  int cycle    = 0;

  always @(posedge clock) cycle <= cycle + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", name, act, exp);
  endtask

  // Packet-level model: a beat is a header when no packet is open; the pattern
  // is one running pixel index whose address and colour fall out by division.
  typedef struct packed {
    bit              in_pkt;
    bit              pkt_ok;
    bit              pattern;
    bit [7:0]        panel;
    bit [15:0]       addr;
    int              quiet;
    int              pos;
    bit [15:0]       drops;
    bit [PANELS-1:0] x_en;
    bit [15:0]       x_addr;
    bit [23:0]       x_wdat;
    bit              x_pat;
  } model_t;

  model_t m;

  function automatic model_t step(input model_t s);
    model_t n = s;
    logic   ok;
    n.x_en  = '0;
    n.x_pat = s.pattern;
    if (s.pattern) begin
      n.x_en   = '1;
      n.x_addr = 16'(s.pos % FILL_WORDS);
      n.x_wdat = (((s.pos / FILL_WORDS) % 2) == 1) ? BLUE : GREEN;
      n.pos    = s.pos + 1;
      n.quiet  = 0;
      if (udp_source_valid) n.pattern = 1'b0;
    end else if (udp_source_valid) begin
      n.quiet = 0;
      if (!s.in_pkt) begin
        ok = (udp_source_dst_port == PORT) && (udp_source_error == 4'd0)
          && (udp_source_data[23:16] == 8'hC5) && (int'(udp_source_data[31:24]) < PANELS);
        if (!ok && s.drops != 16'hFFFF) n.drops = s.drops + 16'd1;
        n.in_pkt = !udp_source_last;
        n.pkt_ok = ok;
        n.panel  = udp_source_data[31:24];
        n.addr   = udp_source_data[15:0];
      end else begin
        if (s.pkt_ok) begin
          n.x_en   = PANELS'(1) << s.panel;
          n.x_addr = s.addr;
          n.x_wdat = udp_source_data[23:0];
        end
        n.addr = s.addr + 16'd1;
        if (udp_source_last) n.in_pkt = 1'b0;
      end
    end else if (!s.in_pkt) begin
      n.quiet = s.quiet + 1;
      if (n.quiet == IDLE_CYCLES) begin
        n.pattern = 1'b1;
        n.pos     = 0;
        n.quiet   = 0;
      end
    end
    return n;
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) m <= '0;
    else       m <= step(m);
  end

  typedef struct packed {
    int              cyc;
    logic [PANELS-1:0] en;
    logic [15:0]     addr;
    logic [23:0]     wdat;
  } wr_t;

  wr_t wlog[$];

  always @(negedge clock) begin
    check("ready", 32'(udp_source_ready), 32'(!reset && !m.pattern));
    check("ctrl_en", 32'(ctrl_en), 32'(m.x_en));
    check("ctrl_wr", 32'(ctrl_wr), (m.x_en != '0) ? 32'd7 : 32'd0);
    if (m.x_en != '0) begin
      check("ctrl_addr", 32'(ctrl_addr), 32'(m.x_addr));
      check("ctrl_wdat", 32'(ctrl_wdat), 32'(m.x_wdat));
    end
    check("pattern_active", 32'(pattern_active), 32'(m.x_pat));
    check("drop_count", 32'(drop_count), 32'(m.drops));
    if (ctrl_en != '0) wlog.push_back('{cycle, ctrl_en, ctrl_addr, ctrl_wdat});
  end

  // Presents one beat from posedge+2 and returns at posedge+2 after it is taken.
  task automatic send(input logic [15:0] port, input logic [3:0] err, input logic [31:0] data,
                      input logic last, output int waits, output int acc_cyc);
    logic acc = 1'b0;
    int   n   = 0;
    waits = 0;
    udp_source_valid    = 1'b1;
    udp_source_dst_port = port;
    udp_source_error    = err;
    udp_source_data     = data;
    udp_source_last     = last;
    while (!acc && n < 20) begin
      @(negedge clock);
      acc = udp_source_ready;
      if (!acc) waits++;
      @(posedge clock);
      #2;
      n++;
    end
    check("handshake", 32'(acc), 32'd1);
    acc_cyc          = cycle;
    udp_source_valid = 1'b0;
    udp_source_last  = 1'b0;
  endtask

  task automatic packet(input logic [15:0] port, input logic [31:0] hdr, input int npix,
                        input logic [31:0] base, output int waits);
    int w, c;
    send(port, 4'd0, hdr, npix == 0, w, c);
    waits = w;
    for (int i = 0; i < npix; i++) begin
      send(port, 4'd0, base + 32'(i) * 32'h00010101, i == npix - 1, w, c);
      waits += w;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  task automatic check_cleared(input string tag);
    check({tag, " en"},   32'(ctrl_en), 32'd0);
    check({tag, " wr"},   32'(ctrl_wr), 32'd0);
    check({tag, " addr"}, 32'(ctrl_addr), 32'd0);
    check({tag, " wdat"}, 32'(ctrl_wdat), 32'd0);
    check({tag, " pat"},  32'(pattern_active), 32'd0);
    check({tag, " drop"}, 32'(drop_count), 32'd0);
    check({tag, " rdy"},  32'(udp_source_ready), 32'd0);
  endtask

  initial begin
    int w, c0, c1, c2, idx, n;

    #1 reset = 1'b1;
    #1 check_cleared("reset");
    @(posedge clock);
    @(posedge clock);
    #2 reset = 1'b0;

    // Single valid packet on panel 2.
    wlog.delete();
    send(PORT, 4'd0, {8'd2, 8'hC5, 16'h0010}, 1'b0, w, c0);
    send(PORT, 4'd0, 32'h00112233, 1'b0, w, c1);
    send(PORT, 4'd0, 32'hFF445566, 1'b1, w, c2);
    idle(2);
    check("t1 count", wlog.size(), 32'd2);
    if (wlog.size() == 2) begin
      check("t1 en0",   32'(wlog[0].en), 32'b000100);
      check("t1 addr0", 32'(wlog[0].addr), 32'h0010);
      check("t1 wdat0", 32'(wlog[0].wdat), 32'h112233);
      check("t1 lat0",  32'(wlog[0].cyc), 32'(c1));
      check("t1 en1",   32'(wlog[1].en), 32'b000100);
      check("t1 addr1", 32'(wlog[1].addr), 32'h0011);
      check("t1 wdat1", 32'(wlog[1].wdat), 32'h445566);
      check("t1 lat1",  32'(wlog[1].cyc), 32'(c2));
    end
    check("t1 drops", 32'(drop_count), 32'd0);

    // Three rejected packets: bad panel, bad magic, wrong port.
    wlog.delete();
    n = 0;
    packet(PORT,     {8'd6, 8'hC5, 16'h0000}, 2, 32'h00010203, w); n += w;
    packet(PORT,     {8'd1, 8'hC4, 16'h0000}, 2, 32'h00010203, w); n += w;
    packet(16'h1234, {8'd1, 8'hC5, 16'h0000}, 2, 32'h00010203, w); n += w;
    idle(2);
    check("t2 writes", wlog.size(), 32'd0);
    check("t2 drops", 32'(drop_count), 32'd3);
    check("t2 stalls", 32'(n), 32'd0);

    // Address wrap; a pixel carrying error!=0 is still written.
    wlog.delete();
    send(PORT, 4'd0, {8'd4, 8'hC5, 16'hFFFE}, 1'b0, w, c0);
    send(PORT, 4'd0, 32'h00A00001, 1'b0, w, c0);
    send(PORT, 4'd3, 32'h00A00002, 1'b0, w, c0);
    send(PORT, 4'd0, 32'h00A00003, 1'b0, w, c0);
    send(PORT, 4'd0, 32'h00A00004, 1'b1, w, c0);
    idle(2);
    check("t3 count", wlog.size(), 32'd4);
    if (wlog.size() == 4) begin
      check("t3 addr0", 32'(wlog[0].addr), 32'hFFFE);
      check("t3 addr1", 32'(wlog[1].addr), 32'hFFFF);
      check("t3 addr2", 32'(wlog[2].addr), 32'h0000);
      check("t3 addr3", 32'(wlog[3].addr), 32'h0001);
      check("t3 en",    32'(wlog[2].en), 32'b010000);
      check("t3 errpx", 32'(wlog[1].wdat), 32'hA00002);
    end

    // Back-to-back: 2-pixel packet, header-only packet, 2-pixel packet.
    wlog.delete();
    packet(PORT, {8'd0, 8'hC5, 16'h0020}, 2, 32'h00A0A0A0, w);
    packet(PORT, {8'd3, 8'hC5, 16'h0030}, 0, 32'h0, w);
    packet(PORT, {8'd5, 8'hC5, 16'h0040}, 2, 32'h00B0B0B0, w);
    idle(2);
    check("t5 count", wlog.size(), 32'd4);
    if (wlog.size() == 4) begin
      check("t5 en0",   32'(wlog[0].en), 32'b000001);
      check("t5 addr1", 32'(wlog[1].addr), 32'h0021);
      check("t5 en2",   32'(wlog[2].en), 32'b100000);
      check("t5 addr2", 32'(wlog[2].addr), 32'h0040);
      check("t5 wdat3", 32'(wlog[3].wdat), 32'hB1B1B1);
      check("t5 gapA",  32'(wlog[1].cyc - wlog[0].cyc), 32'd1);
      // last A pixel, B header, C header, first C pixel on consecutive cycles
      check("t5 gapAC", 32'(wlog[2].cyc - wlog[1].cyc), 32'd3);
    end

    // Reset in the middle of a packet, then the leftover beats arrive.
    send(PORT, 4'd0, {8'd1, 8'hC5, 16'h0200}, 1'b0, w, c0);
    send(PORT, 4'd0, 32'h00AA0001, 1'b0, w, c0);
    send(PORT, 4'd0, 32'h00AA0002, 1'b0, w, c0);
    reset = 1'b1;
    #1 check_cleared("t6 reset");
    @(posedge clock);
    @(posedge clock);
    #2 reset = 1'b0;
    wlog.delete();
    send(PORT, 4'd0, 32'h00AA0003, 1'b0, w, c0);
    send(PORT, 4'd0, 32'h00AA0004, 1'b0, w, c0);
    send(PORT, 4'd0, 32'h00AA0005, 1'b1, w, c0);
    idle(1);
    check("t6 leftover writes", wlog.size(), 32'd0);
    // only the first leftover beat is parsed as a header; the rest are swallowed by DROP
    check("t6 drops", 32'(drop_count), 32'd1);
    packet(PORT, {8'd3, 8'hC5, 16'h0300}, 1, 32'h00123456, w);
    idle(2);
    check("t6 count", wlog.size(), 32'd1);
    if (wlog.size() == 1) begin
      check("t6 en",   32'(wlog[0].en), 32'b001000);
      check("t6 addr", 32'(wlog[0].addr), 32'h0300);
      check("t6 wdat", 32'(wlog[0].wdat), 32'h123456);
    end

    // Idle takeover: one green pass then one blue pass over all panels.
    wlog.delete();
    n = 0;
    while (wlog.size() < 16 && n < 200) begin
      idle(1);
      n++;
    end
    check("t4 wait", 32'(wlog.size() >= 16), 32'd1);
    check("t4 active", 32'(pattern_active), 32'd1);
    if (wlog.size() >= 16) begin
      for (int i = 0; i < 16; i++) begin
        check($sformatf("t4 en%0d", i),   32'(wlog[i].en), 32'h3F);
        check($sformatf("t4 addr%0d", i), 32'(wlog[i].addr), 32'(i % 8));
        check($sformatf("t4 wdat%0d", i), 32'(wlog[i].wdat), (i < 8) ? 32'(GREEN) : 32'(BLUE));
      end
    end
    n = 0;
    while (wlog.size() < 19 && n < 20) begin
      idle(1);
      n++;
    end
    idx = wlog.size();
    check("t4 idx", 32'(idx), 32'd19);
    send(PORT, 4'd0, {8'd1, 8'hC5, 16'h0100}, 1'b0, w, c0);
    check("t4 exit stall", 32'(w), 32'd1);
    send(PORT, 4'd0, 32'h00ABCDEF, 1'b1, w, c0);
    idle(2);
    // one write already registered when valid rose, one in the cycle valid was seen, then the pixel
    check("t4 tail count", wlog.size(), 32'(idx + 3));
    if (wlog.size() == idx + 3) begin
      check("t4 tail en0",   32'(wlog[idx].en), 32'h3F);
      check("t4 tail en1",   32'(wlog[idx + 1].en), 32'h3F);
      check("t4 tail addr1", 32'(wlog[idx + 1].addr), 32'((idx + 1) % 8));
      check("t4 px en",      32'(wlog[idx + 2].en), 32'b000010);
      check("t4 px addr",    32'(wlog[idx + 2].addr), 32'h0100);
      check("t4 px wdat",    32'(wlog[idx + 2].wdat), 32'hABCDEF);
    end
    check("t4 inactive", 32'(pattern_active), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
